// File: rtl/keccak_pkg.sv
// keccak_pkg: definitions shared by the Keccak/SHAKE squeeze datapath.
//   LANE_W               width of one Keccak lane (64 bits)
//   SHAKE128_RATE_LANES  lanes output per permutation for SHAKE128
//   SHAKE256_RATE_LANES  lanes output per permutation for SHAKE256
//   NUM_LANES            lanes in the full 5x5 state
//   keccak_state_t       full state, indexed as A[x][y]
//   squeeze_state_t      FSM states of shake_squeeze
package keccak_pkg;

  localparam int LANE_W              = 64;
  localparam int NUM_LANES           = 25;
  localparam int SHAKE128_RATE_LANES = 21;
  localparam int SHAKE256_RATE_LANES = 17;

  // Outer index is x, middle index is y, so state[x][y] is a single lane.
  typedef logic [4:0][4:0][LANE_W-1:0] keccak_state_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_STATE,
    EMIT,
    PERM,
    DONE
  } squeeze_state_t;

endpackage

// File: rtl/keccak_lane_sel.sv
// keccak_lane_sel: combinational lane picker.
//   state  input  full Keccak state, indexed A[x][y]
//   idx    input  lane index 0..24, where x = idx mod 5 and y = idx div 5
//   lane   output selected 64-bit lane; zero for indices above 24
module keccak_lane_sel
  import keccak_pkg::*;
(
  input  keccak_state_t     state,
  input  logic [4:0]        idx,
  output logic [LANE_W-1:0] lane
);

  // Compare the index against every x + 5*y position instead of dividing
  // by five, so the result is a flat 25:1 mux with no arithmetic.
  always_comb begin
    lane = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        if (idx == 5'(5 * y + x)) begin
          lane = state[x][y];
        end
      end
    end
  end

endmodule

// File: rtl/shake_squeeze.sv
// shake_squeeze: squeeze phase of a SHAKE XOF.  Takes permuted Keccak states,
// streams the rate lanes out one 64-bit lane per handshake, and asks for
// another permutation whenever a rate block is exhausted before the
// requested number of lanes has been delivered.
//
// Parameters:
//   RATE_LANES  lanes emitted per permutation (21 SHAKE128, 17 SHAKE256), 1..25
//   CNT_W       width of the requested-lane counter
// Ports:
//   clk          input   single clock, rising edge
//   rst          input   asynchronous active-high reset
//   set          input   synchronous soft clear back to IDLE
//   req          input   start request, only looked at in IDLE
//   out_lanes    input   number of lanes to emit, sampled with req
//   state_in     input   permuted state, indexed A[x][y]
//   state_valid  input   state_in valid (permutation done pulse)
//   perm_start   output  one-cycle request for the next permutation
//   dout         output  current output lane (zero when not valid)
//   dout_valid   output  dout holds a lane
//   dout_ready   input   consumer accepts dout
//   busy         output  high in every state except IDLE
//   done         output  one-cycle pulse when a request completes
//   dout_last    output  (only with SHAKE_SQUEEZE_LAST_EN) final lane flag
//
// Build option: define SHAKE_SQUEEZE_LAST_EN to add the dout_last port.
module shake_squeeze
  import keccak_pkg::*;
#(
  parameter int RATE_LANES = SHAKE128_RATE_LANES,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set,
  input  logic               req,
  input  logic [CNT_W-1:0]   out_lanes,
  input  keccak_state_t      state_in,
  input  logic               state_valid,
  output logic               perm_start,
  output logic [LANE_W-1:0]  dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               busy,
  output logic               done
`ifdef SHAKE_SQUEEZE_LAST_EN
  ,
  output logic               dout_last
`endif
);

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

  squeeze_state_t      state;
  squeeze_state_t      next_state;
  logic [CNT_W-1:0]    remaining;
  logic [4:0]          lane_idx;
  keccak_state_t       lane_buf;
  logic [LANE_W-1:0]   lane_out;

  logic                handshake;
  logic                final_lane;
  logic                rate_end;

  assign handshake  = (state == EMIT) && dout_ready;
  assign final_lane = (remaining == CNT_W'(1));
  assign rate_end   = (lane_idx == LAST_IDX);

  // State register.  set acts like a synchronous reset of the FSM only;
  // rst still wins because it is checked first and is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (set) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.  In EMIT the end of the request is tested before the
  // rate boundary, so a request ending exactly on the last rate lane finishes
  // without triggering a useless permutation.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (out_lanes == '0) begin
            next_state = DONE;
          end else begin
            next_state = WAIT_STATE;
          end
        end
      end
      WAIT_STATE: begin
        if (state_valid) begin
          next_state = EMIT;
        end
      end
      EMIT: begin
        if (handshake) begin
          if (final_lane) begin
            next_state = DONE;
          end else if (rate_end) begin
            next_state = PERM;
          end
        end
      end
      PERM: begin
        next_state = WAIT_STATE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Counters and state buffer.  The buffer only loads while waiting for a
  // permutation, so a stray state_valid elsewhere leaves it untouched.
  // set clears the counters but keeps the buffer: the next request reloads
  // it before any lane is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      lane_idx  <= '0;
      lane_buf  <= '0;
    end else if (set) begin
      remaining <= '0;
      lane_idx  <= '0;
    end else begin
      if ((state == IDLE) && req && (out_lanes != '0)) begin
        remaining <= out_lanes;
        lane_idx  <= '0;
      end
      if ((state == WAIT_STATE) && state_valid) begin
        lane_buf <= state_in;
      end
      if (handshake) begin
        remaining <= remaining - CNT_W'(1);
        if (rate_end) begin
          lane_idx <= '0;
        end else begin
          lane_idx <= lane_idx + 5'd1;
        end
      end
    end
  end

  keccak_lane_sel u_lane_sel (
    .state (lane_buf),
    .idx   (lane_idx),
    .lane  (lane_out)
  );

  // All outputs decode the registered state, so rst clears them at once and
  // dout cannot change during backpressure (lane_idx only moves on a
  // handshake).  dout is forced to zero outside EMIT.
  assign perm_start = (state == PERM);
  assign dout_valid = (state == EMIT);
  assign done       = (state == DONE);
  assign busy       = (state != IDLE);
  assign dout       = dout_valid ? lane_out : '0;

`ifdef SHAKE_SQUEEZE_LAST_EN
  assign dout_last  = dout_valid && final_lane;
`endif

endmodule

// File: tb/tb_shake_squeeze.sv
// tb_shake_squeeze: directed self-checking bench for shake_squeeze with the
// default SHAKE128 rate (21 lanes).  Test states use A[x][y] = (blk << 56) |
// (x*16 + y), where blk counts the permutations inside one request.
module tb_shake_squeeze;
  import keccak_pkg::*;

  localparam int RATE = 21;

  logic          clk;
  logic          rst;
  logic          set;
  logic          req;
  logic [15:0]   out_lanes;
  keccak_state_t state_in;
  logic          state_valid;
  logic          perm_start;
  logic [63:0]   dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          done;
`ifdef SHAKE_SQUEEZE_LAST_EN
  logic          dout_last;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0] gotLanes[$];
  int          permSeen;
  int          doneSeen;

  shake_squeeze #(.RATE_LANES(RATE), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .set         (set),
    .req         (req),
    .out_lanes   (out_lanes),
    .state_in    (state_in),
    .state_valid (state_valid),
    .perm_start  (perm_start),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .busy        (busy),
    .done        (done)
`ifdef SHAKE_SQUEEZE_LAST_EN
    ,
    .dout_last   (dout_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then land 1 time unit after the rising edge.
  task automatic applyStimulus(input logic r, input logic [15:0] n, input logic sv,
                               input logic rdy, input logic s);
    req         = r;
    out_lanes   = n;
    state_valid = sv;
    dout_ready  = rdy;
    set         = s;
    @(posedge clk);
    #1;
  endtask

  function automatic keccak_state_t mkState(input int blk);
    keccak_state_t st;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        st[x][y] = (64'(blk) << 56) | 64'(x * 16 + y);
      end
    end
    return st;
  endfunction

  function automatic logic [63:0] expLane(input int k);
    int blk;
    int i;
    blk = k / RATE;
    i   = k % RATE;
    return (64'(blk) << 56) | 64'((i % 5) * 16 + (i / 5));
  endfunction

  // Issue a request and act as both permutation core and consumer until done
  // (bounded).  readyPat gives dout_ready for four consecutive cycles, bit 0
  // first.  holdReq keeps req high (with out_lanes=0) while busy.
  task automatic runSqueeze(input int n, input logic [3:0] readyPat, input bit holdReq);
    int   feedWait;
    int   blk;
    int   cyc;
    logic rdy;
    logic sv;
    logic prevStall;
    logic [63:0] prevDout;
    gotLanes.delete();
    permSeen  = 0;
    doneSeen  = 0;
    prevStall = 1'b0;
    prevDout  = '0;
    blk       = 0;
    feedWait  = 1;
    state_in  = mkState(0);
    applyStimulus(1'b1, 16'(n), 1'b0, 1'b1, 1'b0);
    cyc = 0;
    while (cyc < 300 && doneSeen == 0) begin
      if (done) begin
        doneSeen = 1;
      end else begin
        if (perm_start) begin
          permSeen++;
          blk++;
          feedWait = 2;
        end
        sv = 1'b0;
        if (feedWait > 0) begin
          feedWait--;
          if (feedWait == 0) sv = 1'b1;
        end
        state_in = mkState(blk);
        rdy = readyPat[cyc % 4];
        if (prevStall) checkOutput("dout_hold", dout, prevDout);
        if (dout_valid && rdy) begin
          gotLanes.push_back(dout);
`ifdef SHAKE_SQUEEZE_LAST_EN
          checkOutput("dout_last", dout_last, (gotLanes.size() == n) ? 64'd1 : 64'd0);
`endif
        end
        prevStall = dout_valid && !rdy;
        prevDout  = dout;
        applyStimulus(holdReq, 16'd0, sv, rdy, 1'b0);
        cyc++;
      end
    end
    checkOutput("done_reached", 64'(doneSeen), 64'd1);
    checkOutput("lane_count", 64'(gotLanes.size()), 64'(n));
    foreach (gotLanes[k]) checkOutput($sformatf("lane%0d", k), gotLanes[k], expLane(k));
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("done_one_cycle", done, 1'b0);
    checkOutput("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    set         = 1'b0;
    req         = 1'b0;
    out_lanes   = '0;
    state_in    = '0;
    state_valid = 1'b0;
    dout_ready  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_dout_valid", dout_valid, 1'b0);
    checkOutput("rst_dout", dout, 64'd0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_perm_start", perm_start, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

    // Zero-length request: straight to DONE for one cycle
    $display("[TB] zero-length request");
    applyStimulus(1'b1, 16'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("zero_done", done, 1'b1);
    checkOutput("zero_dout_valid", dout_valid, 1'b0);
    checkOutput("zero_perm_start", perm_start, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("zero_done_clear", done, 1'b0);
    checkOutput("zero_busy", busy, 1'b0);
    checkOutput("zero_dout_valid2", dout_valid, 1'b0);

    // Short request: 0x00, 0x10, 0x20
    $display("[TB] short request");
    runSqueeze(3, 4'b1111, 1'b0);
    checkOutput("short_perm", 64'(permSeen), 64'd0);
    if (gotLanes.size() == 3) begin
      checkOutput("short_l0", gotLanes[0], 64'h00);
      checkOutput("short_l1", gotLanes[1], 64'h10);
      checkOutput("short_l2", gotLanes[2], 64'h20);
    end else begin
      checkOutput("short_size", 64'(gotLanes.size()), 64'd3);
    end

    // Rate crossing with req held high to show it is ignored while busy
    $display("[TB] rate crossing");
    runSqueeze(25, 4'b1111, 1'b1);
    checkOutput("cross_perm", 64'(permSeen), 64'd1);
    if (gotLanes.size() == 25) begin
      checkOutput("cross_l20", gotLanes[20], 64'h04);
      checkOutput("cross_l21", gotLanes[21], 64'h0100_0000_0000_0000);
      checkOutput("cross_l24", gotLanes[24], 64'h0100_0000_0000_0030);
    end

    // Backpressure, ready pattern 1,0,0,1
    $display("[TB] backpressure");
    runSqueeze(5, 4'b1001, 1'b0);
    checkOutput("bp_perm", 64'(permSeen), 64'd0);

    // Exact rate boundary: no permutation
    $display("[TB] exact boundary");
    runSqueeze(21, 4'b1111, 1'b0);
    checkOutput("exact_perm", 64'(permSeen), 64'd0);
    if (gotLanes.size() == 21) checkOutput("exact_l20", gotLanes[20], 64'h04);

    // set while waiting for a state, then a stray state_valid
    $display("[TB] soft clear");
    state_in = mkState(0);
    applyStimulus(1'b1, 16'd4, 1'b0, 1'b1, 1'b0);
    checkOutput("set_pre_busy", busy, 1'b1);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("set_busy", busy, 1'b0);
    state_in = mkState(7);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("set_stray_busy", busy, 1'b0);
    checkOutput("set_stray_valid", dout_valid, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("set_stray_valid2", dout_valid, 1'b0);
    runSqueeze(2, 4'b1111, 1'b0);

    // Asynchronous reset in the middle of EMIT
    $display("[TB] reset mid-emit");
    state_in = mkState(0);
    applyStimulus(1'b1, 16'd10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("mid_valid", dout_valid, 1'b1);
    checkOutput("mid_lane0", dout, 64'h00);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("mid_lane1", dout, 64'h10);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_dout", dout, 64'd0);
    checkOutput("arst_valid", dout_valid, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_done", done, 1'b0);
    checkOutput("arst_perm", perm_start, 1'b0);
    #5;
    rst = 1'b0;
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("post_rst_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shake_squeeze.md
SHAKE_SQUEEZE -- requirements
Module: shake_squeeze

Interface
REQ-001 Parameter RATE_LANES, default 21, means output lanes per permutation; 21 for SHAKE128, 17 for SHAKE256.
REQ-002 Parameter CNT_W, default 16, means width of the requested-lane counter.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port set  input  1  synchronous soft clear.
REQ-006 Port req  input  1  start-squeeze request, sampled only in IDLE.
REQ-007 Port out_lanes  input  CNT_W  number of 64-bit lanes to emit, sampled with req.
REQ-008 Port state_in  input  64 x [4:0][4:0]  permuted Keccak state, indexed A[x][y].
REQ-009 Port state_valid  input  1  state_in is valid this cycle (permutation done pulse).
REQ-010 Port perm_start  output  1  one-cycle request for the next permutation.
REQ-011 Port dout  output  64  output lane.
REQ-012 Port dout_valid  output  1  dout holds a valid lane.
REQ-013 Port dout_ready  input  1  consumer accepts dout.
REQ-014 Port busy  output  1  high in every state except IDLE.
REQ-015 Port done  output  1  one-cycle pulse when the request completes.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_STATE, EMIT, PERM and DONE.
REQ-017 IDLE: req with out_lanes=0 SHALL go to DONE; req with out_lanes>0 SHALL load remaining=out_lanes, set lane_idx=0 and go to WAIT_STATE.
REQ-018 WAIT_STATE: state_valid SHALL copy all 25 lanes of state_in into an internal buffer and go to EMIT next cycle.
REQ-019 state_valid outside WAIT_STATE SHALL be ignored, and the buffer SHALL NOT change.
REQ-020 Lane order: lane index i maps to x=i mod 5, y=i div 5; dout=buf[x][y].
REQ-021 EMIT SHALL drive dout_valid=1 and hold dout stable while dout_ready=0.
REQ-022 On an EMIT handshake (dout_valid and dout_ready), remaining SHALL decrement and lane_idx SHALL increment.
REQ-023 EMIT handshake with remaining=1 SHALL go to DONE; this has priority over the rate boundary.
REQ-024 EMIT handshake with lane_idx=RATE_LANES-1 and remaining>1 SHALL go to PERM and reset lane_idx to 0.
REQ-025 PERM SHALL assert perm_start for exactly one cycle, then go to WAIT_STATE.
REQ-026 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-027 In EMIT, throughput SHALL be one lane per cycle when dout_ready is held high; there is no bubble between lanes within one rate block.
REQ-028 req SHALL be ignored while busy=1.
REQ-029 set SHALL force IDLE and clear perm_start, dout_valid and done from any state, including mid-EMIT.

Reset
REQ-030 rst SHALL asynchronously force IDLE with dout=0, dout_valid=0, perm_start=0, done=0, busy=0, remaining=0, lane_idx=0 and the buffer cleared.
REQ-031 rst SHALL take priority over set, and set over all other inputs.

Configuration
REQ-032 With SHAKE_SQUEEZE_LAST_EN defined, an output port dout_last (1 bit) SHALL assert with the final lane of a request (remaining=1); its reset value SHALL be 0.
REQ-033 With SHAKE_SQUEEZE_LAST_EN undefined, the dout_last port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-034 The shared package keccak_pkg SHALL hold LANE_W=64, the state typedef (64-bit [4:0][4:0]), SHAKE128_RATE_LANES=21, SHAKE256_RATE_LANES=17 and the FSM state enum.
REQ-035 One combinational sub-module, keccak_lane_sel, SHALL map a lane index (0..24) to buf[x][y].

Verification
REQ-036 Reset/idle: assert rst mid-EMIT -> all outputs 0 immediately; FSM in IDLE; busy=0.
REQ-037 Zero request: req with out_lanes=0 -> done pulses one cycle later; perm_start, dout_valid never asserted.
REQ-038 Short request: out_lanes=3, state A[x][y]=64'h(x*16+y), dout_ready=1 -> dout sequence 0x00, 0x10, 0x20, then done; no perm_start.
REQ-039 Rate crossing: RATE_LANES=21, out_lanes=25 -> 21 lanes, perm_start pulse, second state_valid, then 4 lanes, then done; lane 21 equals A2[0][0].
REQ-040 Backpressure: dout_ready toggled 1,0,0,1 -> dout held stable while ready=0; no lane lost or duplicated.
REQ-041 Exact boundary plus set: out_lanes=21 -> done after lane 20 with no perm_start; a separate run with set in WAIT_STATE -> IDLE, and a later state_valid is ignored.
